rggen_bus_splitter_fsm: RTL and testbench
=========================================

Name: rggen_bus_splitter_fsm

Overview:
Next-generation splitter between one rggen bus slave port and TOTAL_REGISTERS register interfaces. Adds an explicit IDLE/WAIT/RESPOND state machine so registers may stall `ready` for many cycles. Detects multiple-select decode errors and reports a per-access error pulse. An optional watchdog terminates hung accesses with SLAVE_ERROR. Sits between the bus protocol adapter (APB/AXI-lite bridge) and the register array.

Parameters:
DATA_WIDTH, 32, width of address-independent read/write data paths
TOTAL_REGISTERS, 1, number of register_if channels (≥1)
TIMEOUT_CYCLES, 256, WAIT cycles before watchdog abort (used only with the optional feature; ≥1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
bus_if  rggen_bus_if.slave  interface  upstream bus: request, address, direction, write_data, write_strobe in; done, read_done, write_done, read_data, status out
register_if  rggen_register_if.master  interface array [TOTAL_REGISTERS]  per-register channel: request, address, direction, write_data, write_strob out; select, ready, read_data, status in
busy  output  1  high while state != IDLE
error_pulse  output  1  one-cycle pulse coincident with done when status returned is RGGEN_SLAVE_ERROR

Behaviour:
- Reset (async, rst_n=0): state=IDLE, done/read_done/write_done=0, read_data=0, status=RGGEN_OKAY, busy=0, error_pulse=0, wait counter=0. Reset mid-access aborts it; no done is issued.
- Fan-out: address, direction, write_data, write_strob are driven to all channels unmodified. register_if[i].request = bus_if.request && state!=RESPOND, so registers never see a second request in the done cycle.
- sel = vector of register_if[i].select; rdy = |(ready & sel), so ready from an unselected channel is ignored.
- IDLE:
  - request && sel==0 → RESPOND, status SLAVE_ERROR, read_data 0.
  - request && more than one sel bit → RESPOND, SLAVE_ERROR, read_data 0. Registers may already have committed; this is a decode bug indicator.
  - request && one-hot sel && rdy → RESPOND, capturing that channel's read_data/status.
  - request && one-hot sel && !rdy → WAIT, counter cleared.
  - otherwise stay in IDLE.
- WAIT:
  - request dropped (protocol violation) → IDLE, no done, counter cleared.
  - rdy → RESPOND with captured response.
  - sel changes to zero or multi-hot → RESPOND with SLAVE_ERROR.
  - else counter +1, saturating at its maximum.
- RESPOND: done=1 for exactly one cycle. write_done=1 iff direction==RGGEN_WRITE; read_done=1 iff direction==RGGEN_READ. read_data/status are valid this cycle only. Next state is IDLE unconditionally. Outside RESPOND, read_data=0 and status=RGGEN_OKAY.
- Response mux: AND-OR of the selected channel's {status, read_data}. Registered; no combinational path from register_if to bus_if.
- Latency: ready in request cycle N → done in N+1. ready in WAIT cycle M → done in M+1. Back-to-back accesses: a new request is accepted in the IDLE cycle following RESPOND, giving a 2-cycle minimum spacing.
- Simultaneous: rdy and watchdog expiry in the same cycle → rdy wins (real response returned).
- Outputs busy and error_pulse are registered alongside state/status.

Optional Feature:
Macro RGGEN_BUS_SPLITTER_WATCHDOG_EN.
- Defined: in WAIT, when counter == TIMEOUT_CYCLES-1 and !rdy → RESPOND with SLAVE_ERROR, read_data 0, error_pulse=1. Counter width is $clog2(TIMEOUT_CYCLES+1).
- Undefined: no counter logic is synthesised; WAIT persists until rdy, a select change, or request drop. TIMEOUT_CYCLES is ignored.

Test Plan:
- TOTAL_REGISTERS=4, read of reg 2 with ready in the same cycle and read_data=0xDEADBEEF → done/read_done at +1 cycle, data 0xDEADBEEF, OKAY, error_pulse=0.
- Write to an unmapped address (sel=0) → done/write_done at +1, SLAVE_ERROR, read_data 0, error_pulse=1.
- Reg 1 stalls ready for 5 cycles, then returns 0x00000055 → busy high 6 cycles, done in the cycle after ready, reg1 request low during the done cycle.
- Forced sel=4'b0110 on request → SLAVE_ERROR at +1; then reset asserted during a WAIT stall → all outputs 0/OKAY immediately and no done afterwards.
- Watchdog enabled, TIMEOUT_CYCLES=8, ready never asserts → done with SLAVE_ERROR exactly 9 cycles after the request. A repeat run with ready arriving on the expiry cycle returns OKAY.
- Watchdog disabled, 1000-cycle stall → no done until ready, then a normal OKAY response.

Source files
------------

// File: rtl/rggen_bus_splitter_fsm.sv
// -----------------------------------------------------------------------------
// rggen_bus_splitter_fsm
//
// Splits one rggen bus slave port across TOTAL_REGISTERS register channels.
// An IDLE/WAIT/RESPOND state machine lets registers stall ready for any number
// of cycles. Decode faults (no select, or more than one select) are answered
// with SLAVE_ERROR, and every SLAVE_ERROR response raises error_pulse in the
// done cycle. The response path is fully registered, so there is no
// combinational path from a register channel back to the bus.
//
// Optional feature macro: RGGEN_BUS_SPLITTER_WATCHDOG_EN
//   Defined:   a WAIT that has lasted TIMEOUT_CYCLES cycles without ready is
//              terminated with SLAVE_ERROR.
//   Undefined: no counter exists; WAIT persists until ready, a select change,
//              or the request being dropped. TIMEOUT_CYCLES is ignored.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   bus_request .. bus_write_strobe
//                              upstream request side (from the bus adapter)
//   bus_done, bus_read_done, bus_write_done, bus_read_data, bus_status
//                              upstream response side (registered)
//   register_request .. register_write_strobe
//                              per-channel request fan-out
//   register_select, register_ready, register_read_data, register_status
//                              per-channel decode/response inputs
//   busy                       high while the state machine is not IDLE
//   error_pulse                one-cycle pulse with done on a SLAVE_ERROR
//
// Status encoding: OKAY=2'b00, EXOKAY=2'b01, SLAVE_ERROR=2'b10,
// DECODE_ERROR=2'b11. Direction encoding: READ=0, WRITE=1.
// -----------------------------------------------------------------------------
module rggen_bus_splitter_fsm #(
   parameter int ADDRESS_WIDTH   = 16,
   parameter int DATA_WIDTH      = 32,
   parameter int TOTAL_REGISTERS = 1,
   parameter int TIMEOUT_CYCLES  = 256
) (
   input  logic                                           clk,
   input  logic                                           rst_n,
   // upstream bus
   input  logic                                           bus_request,
   input  logic [ADDRESS_WIDTH-1:0]                       bus_address,
   input  logic                                           bus_direction,
   input  logic [DATA_WIDTH-1:0]                          bus_write_data,
   input  logic [DATA_WIDTH/8-1:0]                        bus_write_strobe,
   output logic                                           bus_done,
   output logic                                           bus_read_done,
   output logic                                           bus_write_done,
   output logic [DATA_WIDTH-1:0]                          bus_read_data,
   output logic [1:0]                                     bus_status,
   // register channels
   output logic [TOTAL_REGISTERS-1:0]                     register_request,
   output logic [TOTAL_REGISTERS-1:0][ADDRESS_WIDTH-1:0]  register_address,
   output logic [TOTAL_REGISTERS-1:0]                     register_direction,
   output logic [TOTAL_REGISTERS-1:0][DATA_WIDTH-1:0]     register_write_data,
   output logic [TOTAL_REGISTERS-1:0][DATA_WIDTH/8-1:0]   register_write_strobe,
   input  logic [TOTAL_REGISTERS-1:0]                     register_select,
   input  logic [TOTAL_REGISTERS-1:0]                     register_ready,
   input  logic [TOTAL_REGISTERS-1:0][DATA_WIDTH-1:0]     register_read_data,
   input  logic [TOTAL_REGISTERS-1:0][1:0]                register_status,
   // status
   output logic                                           busy,
   output logic                                           error_pulse
);

   localparam logic [1:0] RGGEN_OKAY        = 2'b00;
   localparam logic [1:0] RGGEN_SLAVE_ERROR = 2'b10;
   localparam logic       RGGEN_READ        = 1'b0;
   localparam logic       RGGEN_WRITE       = 1'b1;

   // Elaboration-time parameter sanity checks.
   generate
      if (TOTAL_REGISTERS < 1) begin : g_bad_total_registers
         $error("TOTAL_REGISTERS must be at least 1");
      end
      if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
         $error("TIMEOUT_CYCLES must be at least 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_RESPOND = 2'd2
   } state_t;

   state_t                 state_reg;
   logic                   done_reg;
   logic                   read_done_reg;
   logic                   write_done_reg;
   logic [DATA_WIDTH-1:0]  read_data_reg;
   logic [1:0]             status_reg;
   logic                   busy_reg;
   logic                   error_pulse_reg;

`ifdef RGGEN_BUS_SPLITTER_WATCHDOG_EN
   localparam int                 COUNT_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [COUNT_W-1:0] COUNT_LIMIT = COUNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [COUNT_W-1:0] COUNT_MAX   = {COUNT_W{1'b1}};
   logic [COUNT_W-1:0]            wait_count_reg;
`endif

   // Decode view of the register channels
   logic [TOTAL_REGISTERS-1:0]                   sel;
   logic                                         rdy;
   logic                                         sel_one_hot;
   logic [TOTAL_REGISTERS-1:0][DATA_WIDTH-1:0]   masked_data;
   logic [TOTAL_REGISTERS-1:0][1:0]              masked_status;
   logic [DATA_WIDTH-1:0]                        mux_data;
   logic [1:0]                                   mux_status;

   // Per-cycle decisions of the state machine
   logic finish_ok;     // complete with the selected channel's response
   logic finish_err;    // complete with SLAVE_ERROR
   logic finish_any;
   logic enter_wait;    // one-hot select, register not ready yet
   logic abort_wait;    // request withdrawn while waiting: no response

   assign sel         = register_select;
   // Ready from a channel that is not selected must never complete an access.
   assign rdy         = |(register_ready & sel);
   assign sel_one_hot = $onehot(sel);

   // Request fan-out and response masking, one slice per channel.
   // The request is withheld in RESPOND so no register sees a second
   // request while the done for the current one is on the bus.
   generate
      for (genvar gi = 0; gi < TOTAL_REGISTERS; gi++) begin : g_channel
         assign register_request[gi]      = bus_request && (state_reg != ST_RESPOND);
         assign register_address[gi]      = bus_address;
         assign register_direction[gi]    = bus_direction;
         assign register_write_data[gi]   = bus_write_data;
         assign register_write_strobe[gi] = bus_write_strobe;
         assign masked_data[gi]           = register_read_data[gi] & {DATA_WIDTH{sel[gi]}};
         assign masked_status[gi]         = register_status[gi] & {2{sel[gi]}};
      end
   endgenerate

   // AND-OR response mux: only used when sel is one-hot.
   always_comb begin
      mux_data   = '0;
      mux_status = '0;
      for (int i = 0; i < TOTAL_REGISTERS; i++) begin
         mux_data   = mux_data | masked_data[i];
         mux_status = mux_status | masked_status[i];
      end
   end

   always_comb begin
      finish_ok  = 1'b0;
      finish_err = 1'b0;
      enter_wait = 1'b0;
      abort_wait = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (bus_request) begin
               // Zero or multiple selects is a decode fault; registers may
               // already have acted on a multi-hot write.
               if (!sel_one_hot) begin
                  finish_err = 1'b1;
               end else if (rdy) begin
                  finish_ok = 1'b1;
               end else begin
                  enter_wait = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (!bus_request) begin
               abort_wait = 1'b1;
            end else if (!sel_one_hot) begin
               finish_err = 1'b1;
            end else if (rdy) begin
               // Checked before the watchdog so a real response on the
               // expiry cycle is still returned.
               finish_ok = 1'b1;
            end
`ifdef RGGEN_BUS_SPLITTER_WATCHDOG_EN
            else if (wait_count_reg == COUNT_LIMIT) begin
               finish_err = 1'b1;
            end
`endif
         end
         default: begin
         end
      endcase
   end

   assign finish_any = finish_ok || finish_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= ST_IDLE;
         done_reg        <= 1'b0;
         read_done_reg   <= 1'b0;
         write_done_reg  <= 1'b0;
         read_data_reg   <= '0;
         status_reg      <= RGGEN_OKAY;
         busy_reg        <= 1'b0;
         error_pulse_reg <= 1'b0;
`ifdef RGGEN_BUS_SPLITTER_WATCHDOG_EN
         wait_count_reg  <= '0;
`endif
      end else begin
         // Response outputs are non-zero only in the RESPOND cycle.
         done_reg        <= finish_any;
         read_done_reg   <= finish_any && (bus_direction == RGGEN_READ);
         write_done_reg  <= finish_any && (bus_direction == RGGEN_WRITE);
         read_data_reg   <= finish_ok ? mux_data : '0;
         status_reg      <= finish_err ? RGGEN_SLAVE_ERROR :
                            finish_ok  ? mux_status        : RGGEN_OKAY;
         error_pulse_reg <= finish_err || (finish_ok && (mux_status == RGGEN_SLAVE_ERROR));
         // busy mirrors "next state != IDLE"
         busy_reg        <= finish_any || enter_wait ||
                            ((state_reg == ST_WAIT) && !abort_wait);

         case (state_reg)
            ST_IDLE: begin
               if (finish_any) begin
                  state_reg <= ST_RESPOND;
               end else if (enter_wait) begin
                  state_reg <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (abort_wait) begin
                  state_reg <= ST_IDLE;
               end else if (finish_any) begin
                  state_reg <= ST_RESPOND;
               end
            end
            ST_RESPOND: begin
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase

`ifdef RGGEN_BUS_SPLITTER_WATCHDOG_EN
         // Counts cycles spent in WAIT; cleared on entry and whenever the
         // machine is elsewhere.
         if ((state_reg != ST_WAIT) || abort_wait || finish_any) begin
            wait_count_reg <= '0;
         end else if (wait_count_reg != COUNT_MAX) begin
            wait_count_reg <= wait_count_reg + COUNT_W'(1);
         end
`endif
      end
   end

   assign bus_done       = done_reg;
   assign bus_read_done  = read_done_reg;
   assign bus_write_done = write_done_reg;
   assign bus_read_data  = read_data_reg;
   assign bus_status     = status_reg;
   assign busy           = busy_reg;
   assign error_pulse    = error_pulse_reg;

endmodule

// File: tb/tb_rggen_bus_splitter_fsm.sv
// -----------------------------------------------------------------------------
// tb_rggen_bus_splitter_fsm
//
// Drives rggen_bus_splitter_fsm with four register channels. Each access is
// described at transaction level (initial select, cycle at which ready
// arrives, optional select fault, optional request drop) and the expected
// outcome is computed from the access rules with plain arithmetic. Inputs are
// driven and outputs sampled on the falling clock edge.
// Compile with +define+RGGEN_BUS_SPLITTER_WATCHDOG_EN to exercise the
// watchdog build.
// -----------------------------------------------------------------------------
module tb_rggen_bus_splitter_fsm;

   localparam int AW     = 16;
   localparam int DW     = 32;
   localparam int N      = 4;
   localparam int T      = 8;
   localparam int BUDGET = 1100;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] EXOKAY = 2'b01;
   localparam logic [1:0] SLVERR = 2'b10;

   logic                      clk = 1'b0;
   logic                      rst_n;
   logic                      bus_request;
   logic [AW-1:0]             bus_address;
   logic                      bus_direction;
   logic [DW-1:0]             bus_write_data;
   logic [DW/8-1:0]           bus_write_strobe;
   logic                      bus_done;
   logic                      bus_read_done;
   logic                      bus_write_done;
   logic [DW-1:0]             bus_read_data;
   logic [1:0]                bus_status;
   logic [N-1:0]              register_request;
   logic [N-1:0][AW-1:0]      register_address;
   logic [N-1:0]              register_direction;
   logic [N-1:0][DW-1:0]      register_write_data;
   logic [N-1:0][DW/8-1:0]    register_write_strobe;
   logic [N-1:0]              register_select;
   logic [N-1:0]              register_ready;
   logic [N-1:0][DW-1:0]      register_read_data;
   logic [N-1:0][1:0]         register_status;
   logic                      busy;
   logic                      error_pulse;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rggen_bus_splitter_fsm #(
      .ADDRESS_WIDTH   (AW),
      .DATA_WIDTH      (DW),
      .TOTAL_REGISTERS (N),
      .TIMEOUT_CYCLES  (T)
   ) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .bus_request           (bus_request),
      .bus_address           (bus_address),
      .bus_direction         (bus_direction),
      .bus_write_data        (bus_write_data),
      .bus_write_strobe      (bus_write_strobe),
      .bus_done              (bus_done),
      .bus_read_done         (bus_read_done),
      .bus_write_done        (bus_write_done),
      .bus_read_data         (bus_read_data),
      .bus_status            (bus_status),
      .register_request      (register_request),
      .register_address      (register_address),
      .register_direction    (register_direction),
      .register_write_data   (register_write_data),
      .register_write_strobe (register_write_strobe),
      .register_select       (register_select),
      .register_ready        (register_ready),
      .register_read_data    (register_read_data),
      .register_status       (register_status),
      .busy                  (busy),
      .error_pulse           (error_pulse)
   );

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive_idle();
      bus_request     = 1'b0;
      register_select = '0;
      register_ready  = '0;
   endtask

   // One access. sel0: select during the access; r: cycle (0 = request cycle)
   // from which the selected register holds ready; b: cycle at which select
   // switches to bad_sel (0 = never); d: cycle at which request is dropped
   // (0 = never).
   task automatic run_txn(input int id, input logic dir, input logic [N-1:0] sel0, input int r,
                          input int b, input logic [N-1:0] bad_sel, input int d,
                          input logic [DW-1:0] data, input logic [1:0] st);
      int           e;
      int           exp_done;
      int           exp_busy;
      bit           exp_ok;
      logic [1:0]   exp_st;
      logic [DW-1:0] exp_data;
      int           got_done = -1;
      int           busy_cnt = 0;
      int           stray    = 0;
      int           k;
      logic [N-1:0] cur_sel;

      // Reference outcome
      if (!$onehot(sel0)) begin
         e      = 0;
         exp_ok = 1'b0;
      end else begin
         e      = r;
         exp_ok = 1'b1;
         if (b != 0 && b < e) begin
            e      = b;
            exp_ok = 1'b0;
         end
`ifdef RGGEN_BUS_SPLITTER_WATCHDOG_EN
         if (T < e) begin
            e      = T;
            exp_ok = 1'b0;
         end
`endif
      end
      exp_done = (d != 0 && d <= e) ? -1 : e + 1;
      exp_busy = (exp_done > 0) ? exp_done : d;
      exp_st   = exp_ok ? st : SLVERR;
      exp_data = exp_ok ? data : '0;

      // Channel contents: selected channel carries the response, others noise
      bus_address      = AW'($urandom);
      bus_direction    = dir;
      bus_write_data   = $urandom;
      bus_write_strobe = 4'($urandom);
      for (int ch = 0; ch < N; ch++) begin
         if ($onehot(sel0) && sel0[ch]) begin
            register_read_data[ch] = data;
            register_status[ch]    = st;
         end else begin
            register_read_data[ch] = $urandom;
            register_status[ch]    = 2'($urandom);
         end
      end

      for (int c = 0; c < BUDGET; c++) begin
         cur_sel         = (b != 0 && c >= b) ? bad_sel : sel0;
         register_select = cur_sel;
         bus_request     = !(d != 0 && c >= d);
         for (int ch = 0; ch < N; ch++) begin
            register_ready[ch] = cur_sel[ch] ? (c >= r) : 1'($urandom_range(0, 1));
         end
         @(posedge clk);
         @(negedge clk);
         if (c == 0 && busy && !bus_done) begin
            check_value("reg_request_wait", register_request, {N{1'b1}});
         end
         if (busy) busy_cnt++;
         if (bus_done) begin
            got_done = c + 1;
            break;
         end
         if (!busy) break;
      end

      check_value("done_cycle", got_done, exp_done);
      check_value("busy_cycles", busy_cnt, exp_busy);
      if (got_done > 0) begin
         k = $urandom_range(0, N - 1);
         check_value("response", {bus_status, bus_read_data}, {exp_st, exp_data});
         check_value("done_flags", {bus_read_done, bus_write_done, error_pulse},
                     {dir == 1'b0, dir == 1'b1, exp_st == SLVERR});
         check_value("reg_request_done", register_request, '0);
         check_value("fanout", {register_address[k], register_write_data[k],
                                register_write_strobe[k], register_direction[k]},
                     {bus_address, bus_write_data, bus_write_strobe, bus_direction});
      end
      drive_idle();
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus_done || busy || error_pulse || bus_read_done || bus_write_done) stray++;
         if (bus_status != OKAY || bus_read_data != '0) stray++;
      end
      check_value("idle_after", stray, 0);
      $display("txn %0d: dir=%0d sel=%b ready@%0d bad@%0d drop@%0d -> done@%0d status=%0d data=%h",
               id, dir, sel0, r, b, d, got_done, bus_status, exp_data);
   endtask

   task automatic run_reset_abort();
      int stray = 0;
      bus_direction   = 1'b0;
      register_select = 4'b0010;
      register_ready  = '0;
      bus_request     = 1'b1;
      repeat (3) @(negedge clk);
      check_value("rst_pre_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check_value("rst_async", {bus_done, bus_read_done, bus_write_done, busy, error_pulse,
                                bus_status, bus_read_data}, '0);
      @(negedge clk);
      drive_idle();
      rst_n = 1'b1;
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
         if (bus_done || busy) stray++;
      end
      check_value("rst_no_done", stray, 0);
      $display("txn reset-abort: reset asserted during WAIT");
   endtask

   initial begin
      logic [N-1:0] s0;
      logic [N-1:0] bs;
      logic [1:0]   st;
      int           idx;
      int           idx2;
      int           kind;
      int           r;
      int           b;
      int           d;

      rst_n              = 1'b0;
      bus_address        = '0;
      bus_direction      = 1'b0;
      bus_write_data     = '0;
      bus_write_strobe   = '0;
      register_read_data = '0;
      register_status    = '0;
      drive_idle();
      repeat (3) @(negedge clk);
      check_value("reset_state", {bus_done, bus_read_done, bus_write_done, busy, error_pulse,
                                  bus_status, bus_read_data}, '0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed accesses
      run_txn(0, 1'b0, 4'b0100, 0, 0, '0, 0, 32'hDEADBEEF, OKAY);
      run_txn(1, 1'b1, 4'b0000, 0, 0, '0, 0, 32'h12345678, OKAY);
      run_txn(2, 1'b0, 4'b0010, 5, 0, '0, 0, 32'h00000055, OKAY);
      run_txn(3, 1'b1, 4'b0110, 0, 0, '0, 0, 32'hCAFEF00D, OKAY);
      run_reset_abort();
      run_txn(4, 1'b0, 4'b1000, T, 0, '0, 0, 32'hA5A5A5A5, OKAY);
      run_txn(5, 1'b0, 4'b0001, 20, 0, '0, 0, 32'h0BADF00D, OKAY);
      run_txn(6, 1'b1, 4'b0100, 1000, 0, '0, 0, 32'h76543210, EXOKAY);
      run_txn(7, 1'b0, 4'b0001, 0, 0, '0, 0, 32'h11111111, SLVERR);
      run_txn(8, 1'b0, 4'b0010, 6, 3, 4'b0000, 0, 32'h22222222, OKAY);
      run_txn(9, 1'b1, 4'b0010, 6, 0, '0, 2, 32'h33333333, OKAY);

      // Randomized accesses
      for (int n = 10; n < 160; n++) begin
         kind = $urandom_range(0, 9);
         idx  = $urandom_range(0, N - 1);
         idx2 = (idx + $urandom_range(1, N - 1)) % N;
         s0   = '0;
         s0[idx] = 1'b1;
         r    = $urandom_range(0, 12);
         b    = 0;
         d    = 0;
         bs   = '0;
         case ($urandom_range(0, 3))
            0:       st = SLVERR;
            1:       st = EXOKAY;
            default: st = OKAY;
         endcase
         if (kind == 0) begin
            s0 = '0;
         end else if (kind == 1) begin
            s0[idx2] = 1'b1;
         end else if (kind == 2 && r >= 2) begin
            b = $urandom_range(1, r - 1);
            if ($urandom_range(0, 1) == 1) begin
               bs[idx]  = 1'b1;
               bs[idx2] = 1'b1;
            end
         end else if (kind == 3 && r >= 2) begin
            d = $urandom_range(1, r - 1);
         end
         run_txn(n, 1'($urandom_range(0, 1)), s0, r, b, bs, d, $urandom, st);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
